// File: rtl/game_pkg.sv
// Shared game types: symbol codes, name length, entry-FSM states and the
// alphabet stepping rule.
package game_pkg;

  typedef logic [5:0] sym_t;

  localparam sym_t SYM_A     = 6'd10;
  localparam sym_t SYM_Z     = 6'd35;
  localparam sym_t SYM_SPACE = 6'd36;
  localparam int   NAME_LEN  = 5;

  // Button lane order inside name_entry
  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_NEXT = 2;
  localparam int BTN_BACK = 3;
  localparam int NUM_BTN  = 4;

  typedef enum logic [1:0] {IDLE, EDIT, DONE} state_t;

  // Walk A..Z, SPACE cyclically; never leaves 10..36.
  function automatic sym_t sym_step(input sym_t s, input logic up);
    if (up) return (s == SYM_SPACE) ? SYM_A : s + 6'd1;
    return (s == SYM_A) ? SYM_SPACE : s - 6'd1;
  endfunction

endpackage

// File: rtl/btn_cond.sv
// Raw push-button conditioner: 2-flop sync, rising-edge one-shot and optional
// hold-to-repeat. evt is registered, so a press shows up two edges after sampling.
module btn_cond #(
  parameter bit REPEAT_EN     = 1'b0,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic evt
);

  // [0],[1] synchroniser, [2] previous synced level for edge detect
  logic [2:0] sync_pipe;
  logic       rep;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_pipe <= '0;
      evt       <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[1:0], raw};
      evt       <= (sync_pipe[1] & ~sync_pipe[2]) | rep;
    end
  end

  generate
    if (REPEAT_EN) begin : g_rep
      localparam int             CW     = $clog2(REPEAT_DELAY + 1);
      localparam logic [CW-1:0] DLY    = CW'(REPEAT_DELAY);
      // Reloading below DLY makes the counter hit DLY again every PERIOD
      // cycles without ever exceeding DLY, so it cannot wrap.
      localparam logic [CW-1:0] RELOAD = CW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
      logic [CW-1:0] cnt;

      always_ff @(posedge clk or posedge reset) begin
        if (reset)                 cnt <= '0;
        else if (!sync_pipe[1])    cnt <= '0;
        else if (cnt == DLY)       cnt <= RELOAD;
        else                       cnt <= cnt + 1'b1;
      end

      // Gate with the level so a release on the terminal count stays silent
      assign rep = sync_pipe[1] && (cnt == DLY);
    end else begin : g_norep
      assign rep = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/name_entry.sv
// High-score name entry: five-slot symbol editor driven by push buttons,
// armed by enable's rising edge, handing off through saveDone.
module name_entry
  import game_pkg::*;
#(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       btnUp,
  input  logic       btnDown,
  input  logic       btnNext,
  input  logic       btnBack,
  output logic [5:0] letter1,
  output logic [5:0] letter2,
  output logic [5:0] letter3,
  output logic [5:0] letter4,
  output logic [5:0] letter5,
  output logic [2:0] cursor,
  output logic       editing,
  output logic       saveDone
);

  logic [NUM_BTN-1:0] raw, evt;
  assign raw = {btnBack, btnNext, btnDown, btnUp};

  // Only up/down auto-repeat
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_cond #(
      .REPEAT_EN     (i < 2),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_btn (
      .clk   (clk),
      .reset (reset),
      .raw   (raw[i]),
      .evt   (evt[i])
    );
  end

  state_t                    state, state_n;
  logic [NAME_LEN-1:0][5:0]  letters, letters_n;
  logic [2:0]                cursor_n;
  logic                      en_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      letters <= {NAME_LEN{SYM_A}};
      cursor  <= '0;
      en_d    <= 1'b0;
    end else begin
      state   <= state_n;
      letters <= letters_n;
      cursor  <= cursor_n;
      en_d    <= enable;
    end
  end

  always_comb begin
    state_n   = state;
    letters_n = letters;
    cursor_n  = cursor;
    case (state)
      IDLE: begin
        if (enable && !en_d) begin
          letters_n = {NAME_LEN{SYM_A}};
          cursor_n  = '0;
          state_n   = EDIT;
        end
      end
      EDIT: begin
        if (!enable) begin
          state_n = IDLE;
        end else if (evt[BTN_NEXT]) begin
          if (cursor == 3'(NAME_LEN - 1)) state_n = DONE;
          else                            cursor_n = cursor + 3'd1;
        end else if (evt[BTN_BACK]) begin
          if (cursor != 3'd0) cursor_n = cursor - 3'd1;
        end else if (evt[BTN_UP] ^ evt[BTN_DOWN]) begin
          letters_n[cursor] = sym_step(letters[cursor], evt[BTN_UP]);
        end
      end
      DONE: begin
        if (!enable) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign letter1  = letters[0];
  assign letter2  = letters[1];
  assign letter3  = letters[2];
  assign letter4  = letters[3];
  assign letter5  = letters[4];
  assign editing  = (state == EDIT);
  assign saveDone = (state == DONE);

endmodule

// File: tb/tb_name_entry.sv
// Directed bench for name_entry with short repeat timing (delay 8, period 4).
module tb_name_entry;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       btnUp, btnDown, btnNext, btnBack;
  logic [5:0] letter1, letter2, letter3, letter4, letter5;
  logic [2:0] cursor;
  logic       editing, saveDone;

  int n_chk  = 0;
  int n_fail = 0;

  name_entry #(.REPEAT_DELAY(8), .REPEAT_PERIOD(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .btnUp    (btnUp),
    .btnDown  (btnDown),
    .btnNext  (btnNext),
    .btnBack  (btnBack),
    .letter1  (letter1),
    .letter2  (letter2),
    .letter3  (letter3),
    .letter4  (letter4),
    .letter5  (letter5),
    .cursor   (cursor),
    .editing  (editing),
    .saveDone (saveDone)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // m = {back, next, down, up}; short press, then enough idle for the event to land
  task automatic tap(input logic [3:0] m);
    {btnBack, btnNext, btnDown, btnUp} = m;
    tick(2);
    {btnBack, btnNext, btnDown, btnUp} = 4'b0000;
    tick(4);
  endtask

  localparam logic [3:0] UP = 4'b0001, DN = 4'b0010, NX = 4'b0100, BK = 4'b1000;

  initial begin
    int e;
    reset = 1'b1; enable = 1'b0;
    {btnBack, btnNext, btnDown, btnUp} = 4'b0000;
    tick(2);
    chk("rst_editing", editing, 0);
    chk("rst_saveDone", saveDone, 0);
    chk("rst_cursor", cursor, 0);
    chk("rst_letter1", letter1, 10);
    chk("rst_letter5", letter5, 10);
    reset = 1'b0;
    tick(2);

    // Arm entry
    enable = 1'b1;
    chk("pre_editing", editing, 0);
    tick(1);
    chk("en_editing", editing, 1);
    chk("en_cursor", cursor, 0);
    chk("en_saveDone", saveDone, 0);
    chk("en_letter1", letter1, 10);
    chk("en_letter2", letter2, 10);
    chk("en_letter3", letter3, 10);
    chk("en_letter4", letter4, 10);
    chk("en_letter5", letter5, 10);

    // Held up: steps after edges +3, +11, +15, +19 (k = 4, 12, 16, 20)
    btnUp = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      if (k == 21) btnUp = 1'b0;
      tick(1);
      e = 10 + int'(k >= 4) + int'(k >= 12) + int'(k >= 16) + int'(k >= 20);
      chk($sformatf("hold_k%0d", k), letter1, e);
    end
    tick(4);
    chk("hold_final", letter1, 14);

    // Leaving EDIT keeps the partial name; re-arming clears it
    enable = 1'b0;
    tick(1);
    chk("drop_editing", editing, 0);
    chk("drop_keep", letter1, 14);
    tick(2);
    chk("idle_keep", letter1, 14);
    enable = 1'b1;
    tick(1);
    chk("rearm_letter1", letter1, 10);
    chk("rearm_editing", editing, 1);

    // 27 taps walk 11..36 and wrap back to 10
    e = 10;
    for (int i = 0; i < 27; i++) begin
      tap(UP);
      e = (e == 36) ? 10 : e + 1;
      chk($sformatf("wrap_up%0d", i), letter1, e);
    end
    chk("wrap_end", letter1, 10);

    // 3 ups, next, down
    tap(UP); tap(UP); tap(UP);
    tap(NX);
    tap(DN);
    chk("seq_letter1", letter1, 13);
    chk("seq_letter2", letter2, 36);
    chk("seq_cursor", cursor, 1);

    // Simultaneous up+down: no change
    tap(UP | DN);
    chk("updn_letter2", letter2, 36);
    chk("updn_cursor", cursor, 1);
    // Next wins over up
    tap(NX | UP);
    chk("nxup_cursor", cursor, 2);
    chk("nxup_letter2", letter2, 36);
    chk("nxup_letter3", letter3, 10);
    // Back wins over down
    tap(BK | DN);
    chk("bkdn_cursor", cursor, 1);
    chk("bkdn_letter2", letter2, 36);
    tap(BK);
    chk("back_cursor0", cursor, 0);
    tap(BK);
    chk("back_at0", cursor, 0);

    // Advance to the last slot, then commit
    tap(NX); tap(NX); tap(NX); tap(NX);
    chk("last_cursor", cursor, 4);
    chk("last_saveDone", saveDone, 0);
    btnNext = 1'b1;
    tick(2);
    btnNext = 1'b0;
    tick(1);
    chk("commit_pending", saveDone, 0);
    tick(1);
    chk("commit_saveDone", saveDone, 1);
    chk("commit_editing", editing, 0);
    tap(UP);
    tap(BK);
    chk("frozen_letter1", letter1, 13);
    chk("frozen_letter5", letter5, 10);
    chk("frozen_cursor", cursor, 4);
    chk("frozen_saveDone", saveDone, 1);
    enable = 1'b0;
    tick(1);
    chk("release_saveDone", saveDone, 0);
    chk("release_editing", editing, 0);

    // Reset in the middle of an edit
    enable = 1'b1;
    tick(1);
    tap(UP);
    tap(NX);
    chk("mid_letter1", letter1, 11);
    chk("mid_cursor", cursor, 1);
    btnUp = 1'b1;
    tick(1);
    reset = 1'b1;
    #2;
    chk("async_letter1", letter1, 10);
    chk("async_cursor", cursor, 0);
    chk("async_editing", editing, 0);
    chk("async_saveDone", saveDone, 0);
    btnUp = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(6);
    chk("post_rst_letter1", letter1, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/name_entry.md
# name_entry

Upstream input stage for the arcade basketball game top. After a round ends it lets the player spell a five-symbol high-score name using push buttons, with hold-to-repeat. It drives the `letter1`..`letter5` symbol codes and the `saveDone` handshake that the game top, score keeper and timer consume.

## Interface
- `REPEAT_DELAY`, default 25_000_000: cycles a held up/down button must stay high before auto-repeat starts.
- `REPEAT_PERIOD`, default 5_000_000: cycles between auto-repeat steps.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  level input; high while name entry is allowed (game over).
- `btnUp`  in  1  raw button; next symbol.
- `btnDown`  in  1  raw button; previous symbol.
- `btnNext`  in  1  raw button; commit the slot and advance the cursor.
- `btnBack`  in  1  raw button; move the cursor back one slot.
- `letter1`..`letter5`  out  6 each  symbol codes. `letter1` is the leftmost slot.
- `cursor`  out  3  slot being edited, 0..4.
- `editing`  out  1  high in state EDIT.
- `saveDone`  out  1  high in state DONE.

## Operation
- Symbol alphabet: SYM_A=10 through SYM_Z=35, then SYM_SPACE=36.
  - Up steps +1. 36 wraps to 10.
  - Down steps −1. 10 wraps to 36.
  - No other code is ever produced.
- State IDLE:
  - `editing`=0, `saveDone`=0.
  - Letters hold their last values.
  - On a rising edge of `enable`: all letters ← SYM_A, `cursor` ← 0, go to EDIT.
- State EDIT, per cycle, with the following priority:
  1. `btnNext` event:
     - If `cursor`<4: `cursor`+1.
     - If `cursor`=4: go to DONE.
  2. Else `btnBack` event: `cursor`−1. Ignored at 0.
  3. Else exactly one of the up/down events: step the letter at the cursor. Up and down in the same cycle: no change.
  - Up/down events are discarded in any cycle that has a next or back event.
- State DONE:
  - `saveDone`=1 and `editing`=0.
  - Letters are frozen.
  - Remains until `enable` falls, then goes to IDLE.
- `enable` falling while in EDIT: go to IDLE. Letters keep their partial values.
- Button conditioning, per button:
  - Two-flop synchroniser, then rising-edge detect. The result is a one-cycle event.
  - Up/down only: auto-repeat.
    - Counter is cleared while the synchronised level is low.
    - Emits an extra event when the counter reaches REPEAT_DELAY.
    - Then emits one every REPEAT_PERIOD cycles while the button is held.
- Counters are `$clog2(REPEAT_DELAY+1)` bits wide. Saturating and wrapping never cause a spurious event.

## Timing
- Reset values:
  - state IDLE
  - letters = SYM_A
  - `cursor`=0
  - `editing`=0
  - `saveDone`=0
  - synchroniser and repeat counters all 0
- Raw button rising at edge N: the event is internal at N+2, and the letter/cursor output changes after edge N+3.
- `enable` rising at edge N (already synchronous): `editing`=1 and letters=SYM_A after edge N+1.
- `saveDone` rises the cycle after the final next event, and falls the cycle after `enable` is seen low.
- Held up button: first step at +3 cycles. Second step REPEAT_DELAY cycles after the first. Further steps every REPEAT_PERIOD.
- Reset mid-edit: all outputs return to reset values immediately (asynchronous). Pending events are lost.

## Structure
- Shared package `game_pkg` holds:
  - SYM_A, SYM_Z, SYM_SPACE
  - NAME_LEN=5
  - state enum (IDLE, EDIT, DONE)
- Sub-module `btn_cond` (synchroniser, edge detect, optional auto-repeat enabled by a parameter), instanced four times. Repeat is disabled for next/back.

## Test plan
- Reset, then pulse `enable` → after 1 cycle, `editing`=1, all letters=10, `cursor`=0, `saveDone`=0.
- Three up taps, one next, one down tap → `letter1`=13, `letter2`=36 (wrapped from 10), `cursor`=1.
- Slot 0, up tapped 27 times from 10 → walks 11..36 then back to 10. No code outside 10..36.
- REPEAT_DELAY=8, REPEAT_PERIOD=4, up held 20 cycles → steps at +3, +11, +15, +19; `letter1`=14.
- Up and down in the same cycle → no change. Next and up in the same cycle → cursor advances, letter unchanged. Back at cursor 0 → cursor stays 0.
- Five nexts → `saveDone`=1 with letters frozen. Drop `enable` → IDLE next cycle with `saveDone`=0. Assert `reset` mid-EDIT → outputs at reset values in the same cycle.
